// File: rtl/stand_mode_exit_gesture.sv
// Purpose: detect a reverse swipe (sensor B then sensor A) in standby and request exit to OFF.
// Latency: rise of A sampled at edge n drives stand_exit_toggle high for cycle n+1 only.
// Backpressure: none; HOLD suppresses repeat requests until both sensors are low or mode leaves standby.
module stand_mode_exit_gesture #(
    parameter int                MODE_W      = 3,
    parameter int                TIME_W      = 8,
    parameter logic [MODE_W-1:0] STAND_CODE  = MODE_W'(1),
    parameter int                TICK_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              first_toggle_signal,
    input  logic              second_toggle_signal,
    input  logic [MODE_W-1:0] current_mode,
    input  logic [TIME_W-1:0] counter_time,
    output logic              stand_exit_toggle,
    output logic              gesture_armed,
    output logic [TIME_W-1:0] window_remaining
);

    localparam int PSC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              a_d, b_d;
    logic [PSC_W-1:0]  prescaler, prescaler_nxt;
    logic [TIME_W-1:0] window_nxt;
    logic              toggle_nxt;

    logic rise_a, rise_b, in_stand, tick;

    assign rise_a   = first_toggle_signal & ~a_d;
    assign rise_b   = second_toggle_signal & ~b_d;
    assign in_stand = (current_mode == STAND_CODE);
    assign tick     = (prescaler == PSC_LAST);

    // ARMED is the only state that exposes the armed flag; it is a decode of the state register
    assign gesture_armed = (state == ARMED);

    // State, edge history, window counter and pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            a_d               <= 1'b1;  // held-high inputs through reset must not look like edges
            b_d               <= 1'b1;
            prescaler         <= '0;
            window_remaining  <= '0;
            stand_exit_toggle <= 1'b0;
        end else begin
            state             <= state_nxt;
            a_d               <= first_toggle_signal;
            b_d               <= second_toggle_signal;
            prescaler         <= prescaler_nxt;
            window_remaining  <= window_nxt;
            stand_exit_toggle <= toggle_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        window_nxt    = window_remaining;
        prescaler_nxt = '0;
        toggle_nxt    = 1'b0;
        case (state)
            IDLE: begin
                window_nxt = '0;
                // simultaneous A/B edges give no direction, so they never arm
                if (in_stand && rise_b && !rise_a && (counter_time != '0)) begin
                    state_nxt  = ARMED;
                    window_nxt = counter_time;
                end
            end
            ARMED: begin
                if (!in_stand) begin
                    state_nxt  = IDLE;
                    window_nxt = '0;
                end else if (rise_a) begin
                    // A wins over the decrement, so an edge on the final tick still counts
                    state_nxt  = HOLD;
                    window_nxt = '0;
                    toggle_nxt = 1'b1;
                end else if (tick) begin
                    if (window_remaining <= TIME_W'(1)) begin
                        window_nxt = '0;
                        state_nxt  = IDLE;
                    end else begin
                        window_nxt = window_remaining - TIME_W'(1);
                    end
                end else begin
                    prescaler_nxt = prescaler + PSC_W'(1);
                end
            end
            HOLD: begin
                window_nxt = '0;
                if (!in_stand || (!first_toggle_signal && !second_toggle_signal)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                window_nxt = '0;
            end
        endcase
    end

endmodule
